// File: rtl/program_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
package program_loader_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HEADER,
      ST_PAYLOAD,
      ST_CHECK,
      ST_DONE,
      ST_ERROR
   } state_e;

   localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;
   localparam int          DEFAULT_MEMORY_DEPTH = 32;

   // Word index must be able to hold MEMORY_DEPTH itself, hence the +1.
   function automatic int word_idx_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   localparam int WORD_IDX_W = word_idx_width(DEFAULT_MEMORY_DEPTH);

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface program_loader_if;

   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;

   modport master (
      input  byte_valid, byte_data,
      output byte_ready, mem_we, mem_addr, mem_wdata
   );

   modport slave (
      output byte_valid, byte_data,
      input  byte_ready, mem_we, mem_addr, mem_wdata
   );

endinterface

// File: rtl/program_loader_byte_word_assembler.sv
// Packs little-endian stream bytes into 32-bit words; word_ready_o marks the 4th byte.
module byte_word_assembler (
   input  logic        clk,
   input  logic        reset,
   input  logic        clear_i,
   input  logic        byte_en_i,
   input  logic [7:0]  byte_i,
   output logic        word_ready_o,
   output logic [31:0] word_o
);

   logic [1:0]  byte_idx_q, byte_idx_d;
   logic [23:0] shift_q, shift_d;

   // Only the first three bytes are stored; the fourth completes the word directly.
   assign word_ready_o = byte_en_i && (byte_idx_q == 2'd3);
   assign word_o       = {byte_i, shift_q};

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      byte_idx_d = byte_idx_q;
      shift_d    = shift_q;
      if (clear_i) begin
         byte_idx_d = '0;
         shift_d    = '0;
      end else if (byte_en_i) begin
         byte_idx_d = byte_idx_q + 2'd1;
         shift_d    = {byte_i, shift_q[23:8]};
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignments so all flops update together.
      if (reset) begin
         byte_idx_q <= '0;
         shift_q    <= '0;
      end else begin
         byte_idx_q <= byte_idx_d;
         shift_q    <= shift_d;
      end
   end

endmodule

// File: rtl/program_loader.sv
// Loads a framed, checksummed program into instruction memory and holds the core
// in reset until a frame has loaded cleanly.
module program_loader
   import program_loader_pkg::*;
#(
   parameter int          MEMORY_DEPTH = DEFAULT_MEMORY_DEPTH,
   parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   program_loader_if.master  bus,
   output logic              cpu_reset,
   output logic              done,
   output logic              error
);

   localparam int IDX_W = word_idx_width(MEMORY_DEPTH);

   state_e            state_q, state_d;
   logic [7:0]        count_q, count_d;
   logic [IDX_W-1:0]  word_idx_q, word_idx_d;
   logic [7:0]        checksum_q, checksum_d;
   logic              byte_ready_q, byte_ready_d;
   logic              mem_we_q, mem_we_d;
   logic [31:0]       mem_addr_q, mem_addr_d;
   logic [31:0]       mem_wdata_q, mem_wdata_d;
   logic              cpu_reset_q, cpu_reset_d;
   logic              done_q, done_d;
   logic              error_q, error_d;

   logic              accept;
   logic              header_bad;
   logic              last_word;
   logic              word_ready;
   logic [31:0]       word;

   assign accept     = bus.byte_valid && byte_ready_q;
   assign header_bad = (bus.byte_data == 8'd0) ||
                       (32'(bus.byte_data) > 32'(MEMORY_DEPTH));
   assign last_word  = (32'(word_idx_q) + 32'd1) == 32'(count_q);

   byte_word_assembler u_assembler (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (accept && (state_q == ST_HEADER)),
      .byte_en_i    (accept && (state_q == ST_PAYLOAD)),
      .byte_i       (bus.byte_data),
      .word_ready_o (word_ready),
      .word_o       (word)
   );

   always_comb begin
      state_d     = state_q;
      count_d     = count_q;
      word_idx_d  = word_idx_q;
      checksum_d  = checksum_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = ST_HEADER;
         end
         ST_HEADER: begin
            if (accept) begin
               if (header_bad) begin
                  state_d = ST_ERROR;
               end else begin
                  count_d    = bus.byte_data;
                  word_idx_d = '0;
                  checksum_d = '0;
                  state_d    = ST_PAYLOAD;
               end
            end
         end
         ST_PAYLOAD: begin
            if (accept) begin
               checksum_d = checksum_q ^ bus.byte_data;
               if (word_ready) begin
                  mem_we_d    = 1'b1;
                  mem_addr_d  = BASE_ADDRESS + 32'({word_idx_q, 2'b00});
                  mem_wdata_d = word;
                  word_idx_d  = word_idx_q + IDX_W'(1);
                  if (last_word) state_d = ST_CHECK;
               end
            end
         end
         ST_CHECK: begin
            if (accept) state_d = (bus.byte_data == checksum_q) ? ST_DONE : ST_ERROR;
         end
         ST_DONE, ST_ERROR: begin
            if (start) state_d = ST_HEADER;
         end
         default: state_d = ST_IDLE;
      endcase

      // Status outputs are registered decodes of the next state.
      byte_ready_d = (state_d == ST_HEADER) || (state_d == ST_PAYLOAD) || (state_d == ST_CHECK);
      cpu_reset_d  = (state_d != ST_DONE);
      done_d       = (state_d == ST_DONE);
      error_d      = (state_d == ST_ERROR);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         count_q      <= '0;
         word_idx_q   <= '0;
         checksum_q   <= '0;
         byte_ready_q <= 1'b0;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= BASE_ADDRESS;
         mem_wdata_q  <= '0;
         cpu_reset_q  <= 1'b1;
         done_q       <= 1'b0;
         error_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         count_q      <= count_d;
         word_idx_q   <= word_idx_d;
         checksum_q   <= checksum_d;
         byte_ready_q <= byte_ready_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wdata_q  <= mem_wdata_d;
         cpu_reset_q  <= cpu_reset_d;
         done_q       <= done_d;
         error_q      <= error_d;
      end
   end

   assign bus.byte_ready = byte_ready_q;
   assign bus.mem_we     = mem_we_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign cpu_reset      = cpu_reset_q;
   assign done           = done_q;
   assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Bench for program_loader: frame-level reference model, per-cycle output compare,
// directed frames plus randomized traffic.
module tb_program_loader;

   localparam int          DEPTH = 32;
   localparam logic [31:0] BASE  = 32'h0040_0000;

   logic clk = 1'b0;
   logic reset, start, cpu_reset, done, error;

   program_loader_if bus ();

   program_loader #(.MEMORY_DEPTH(DEPTH), .BASE_ADDRESS(BASE)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .bus       (bus.master),
      .cpu_reset (cpu_reset),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;
   int we_count   = 0;
   bit cmp_en     = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum {M_IDLE, M_LOAD, M_DONE, M_ERR} phase_e;
   phase_e      m_phase     = M_IDLE;
   logic        m_ready     = 1'b0;
   logic        m_we        = 1'b0;
   logic [31:0] m_addr      = BASE;
   logic [31:0] m_wdata     = '0;
   logic        m_cpu_reset = 1'b1;
   logic        m_done      = 1'b0;
   logic        m_error     = 1'b0;
   logic [7:0]  acc[$];

   function automatic void m_finish(input bit ok);
      m_phase     = ok ? M_DONE : M_ERR;
      m_ready     = 1'b0;
      m_done      = ok;
      m_error     = !ok;
      m_cpu_reset = !ok;
   endfunction

   // Updates one step after each rising edge, from the inputs held across that edge.
   always begin : model
      int         j, n;
      logic [7:0] x;
      @(posedge clk);
      #1;
      m_we = 1'b0;
      if (reset) begin
         m_phase = M_IDLE; m_ready = 1'b0; m_addr = BASE; m_wdata = '0;
         m_cpu_reset = 1'b1; m_done = 1'b0; m_error = 1'b0;
         acc.delete();
      end else if (start && m_phase != M_LOAD) begin
         m_phase = M_LOAD; m_ready = 1'b1; m_done = 1'b0; m_error = 1'b0; m_cpu_reset = 1'b1;
         acc.delete();
      end else if (m_phase == M_LOAD && bus.byte_valid && m_ready) begin
         acc.push_back(bus.byte_data);
         j = acc.size();
         n = int'(acc[0]);
         if (j == 1) begin
            if (n == 0 || n > DEPTH) m_finish(1'b0);
         end else if (j <= 4 * n + 1) begin
            if ((j - 1) % 4 == 0) begin
               m_we    = 1'b1;
               m_addr  = BASE + 32'(4 * ((j - 1) / 4 - 1));
               m_wdata = {acc[j-1], acc[j-2], acc[j-3], acc[j-4]};
            end
         end else begin
            x = 8'h00;
            for (int k = 1; k <= 4 * n; k++) x ^= acc[k];
            m_finish(acc[j-1] == x);
         end
      end
   end

   // Per-cycle comparison of every output against the model.
   always @(negedge clk) begin
      if (bus.mem_we === 1'b1) we_count++;
      if (cmp_en) begin
         check("byte_ready", 32'(bus.byte_ready), 32'(m_ready));
         check("mem_we",     32'(bus.mem_we),     32'(m_we));
         check("mem_addr",   bus.mem_addr,        m_addr);
         check("mem_wdata",  bus.mem_wdata,       m_wdata);
         check("cpu_reset",  32'(cpu_reset),      32'(m_cpu_reset));
         check("done",       32'(done),           32'(m_done));
         check("error",      32'(error),          32'(m_error));
      end
   end

   // ---------------- stimulus ----------------
   logic [7:0] frame_q[$];

   task automatic build_frame(input int n, input bit bad_sum);
      logic [31:0] w;
      logic [7:0]  x;
      frame_q.delete();
      frame_q.push_back(8'(n));
      x = 8'h00;
      for (int i = 0; i < n; i++) begin
         w = $urandom;
         for (int b = 0; b < 4; b++) begin
            frame_q.push_back(w[8*b +: 8]);
            x ^= w[8*b +: 8];
         end
      end
      frame_q.push_back(bad_sum ? (x ^ 8'($urandom_range(1, 255))) : x);
   endtask

   task automatic do_reset(input int cycles);
      reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0;
      repeat (cycles) @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic pulse_start(input bit with_byte);
      @(negedge clk);
      start = 1'b1;
      bus.byte_valid = with_byte;
      bus.byte_data  = frame_q[0];
      @(negedge clk);
      start = 1'b0;
      bus.byte_valid = 1'b0;
   endtask

   task automatic send_bytes(input int pct, input bit noise);
      int i = 0;
      int budget = 0;
      forever begin
         @(negedge clk);
         if (i >= frame_q.size() || m_phase != M_LOAD) break;
         if (budget++ > 4000) begin
            vectors++; miscompares++;
            $display("FAIL timeout: %0d of %0d bytes sent", i, frame_q.size());
            break;
         end
         bus.byte_valid = ($urandom_range(99) < pct);
         bus.byte_data  = bus.byte_valid ? frame_q[i] : 8'($urandom);
         start          = noise && ($urandom_range(9) == 0);
         if (bus.byte_valid && m_ready) i++;
      end
      bus.byte_valid = 1'b0;
      start = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      int base_we;
      reset = 1'b1; start = 1'b0; bus.byte_valid = 1'b0; bus.byte_data = '0;
      repeat (3) @(negedge clk);
      cmp_en = 1'b1;
      check("rst_ready",     32'(bus.byte_ready), 32'd0);
      check("rst_addr",      bus.mem_addr,        32'h0040_0000);
      check("rst_cpu_reset", 32'(cpu_reset),      32'd1);
      reset = 1'b0;

      // Single-word frame: word 0x20080020, XOR checksum 20^00^08^20 = 08.
      frame_q = '{8'h01, 8'h20, 8'h00, 8'h08, 8'h20, 8'h08};
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t1_we_count",  32'(we_count),   32'd1);
      check("t1_addr",      bus.mem_addr,    32'h0040_0000);
      check("t1_wdata",     bus.mem_wdata,   32'h2008_0020);
      check("t1_done",      32'(done),       32'd1);
      check("t1_cpu_reset", 32'(cpu_reset),  32'd0);

      // Three words back to back.
      build_frame(3, 1'b0);
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t2_we_count",  32'(we_count),   32'd4);
      check("t2_last_addr", bus.mem_addr,    32'h0040_0008);

      // Illegal headers: zero and MEMORY_DEPTH+1.
      base_we = we_count;
      frame_q = '{8'h00, 8'h11, 8'h22};
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t3_error0",    32'(error),      32'd1);
      frame_q = '{8'h21, 8'h11, 8'h22};
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t3_error33",   32'(error),      32'd1);
      check("t3_cpu_reset", 32'(cpu_reset),  32'd1);
      check("t3_no_we",     32'(we_count),   32'(base_we));

      // Bad checksum: the word is still written; then recover with a good frame,
      // presenting the header byte in the start cycle where it must not be taken.
      frame_q = '{8'h01, 8'h20, 8'h00, 8'h08, 8'h20, 8'h00};
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t4_we",        32'(we_count),   32'(base_we + 1));
      check("t4_error",     32'(error),      32'd1);
      check("t4_done",      32'(done),       32'd0);
      build_frame(2, 1'b0);
      pulse_start(1'b1);
      send_bytes(100, 1'b0);
      check("t4_recover",   32'(done),       32'd1);

      // Reset after two payload bytes: no write, outputs back to reset values.
      base_we = we_count;
      frame_q = '{8'h01, 8'h11, 8'h22};
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      do_reset(2);
      check("t5_no_we",     32'(we_count),   32'(base_we));
      check("t5_wdata",     bus.mem_wdata,   32'h0000_0000);
      check("t5_addr",      bus.mem_addr,    32'h0040_0000);
      build_frame(1, 1'b0);
      pulse_start(1'b0);
      send_bytes(100, 1'b0);
      check("t5_reload",    32'(done),       32'd1);

      // Largest legal frame.
      build_frame(DEPTH, 1'b0);
      pulse_start(1'b0);
      send_bytes(80, 1'b0);
      check("t6_max_addr",  bus.mem_addr,    32'h0040_007C);

      // Random gaps in byte_valid, stray start pulses, occasional bad checksums.
      for (int f = 0; f < 14; f++) begin
         build_frame($urandom_range(1, 9), $urandom_range(3) == 0);
         pulse_start($urandom_range(1));
         send_bytes($urandom_range(30, 100), 1'b1);
      end

      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
